vec_normalizer_seq: RTL and testbench



---
 rtl/vec_normalizer_seq.sv | 195 +++++++++++++++++++
 tb/tb_vec_normalizer_seq.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/vec_normalizer_seq.sv
// Sequential N-channel vector normaliser: out_k = floor(x_k * 2^FRAC_BITS / isqrt(sum x_j^2)).
// Latency: o_valid rises N + RW + N*NB cycles after the accepting edge; one vector in flight.
// Backpressure: i_ready only in IDLE; the result is held stable in OUT until o_ready.
//
// Ports:
//   clk, rst          clock, asynchronous active-low reset
//   i_valid/i_ready   input handshake; i_data holds channel k at [k*DATAWIDTH +: DATAWIDTH]
//   o_valid/o_ready   output handshake; o_data holds quotient k at [k*QW +: QW], QW = 2*DATAWIDTH+2
//   o_zero            all inputs were zero (only meaningful while o_valid)
module vec_normalizer_seq #(
  parameter int DATAWIDTH    = 4,
  parameter int FRAC_BITS    = 4,
  parameter int NUM_CHANNELS = 4,
  parameter int INSTANCE_ID  = 0
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   i_valid,
  output logic                                   i_ready,
  input  logic [NUM_CHANNELS*DATAWIDTH-1:0]       i_data,
  output logic                                   o_valid,
  input  logic                                   o_ready,
  output logic [NUM_CHANNELS*(2*DATAWIDTH+2)-1:0] o_data,
  output logic                                   o_zero
);

  localparam int SW   = 2*DATAWIDTH + $clog2(NUM_CHANNELS);  // sum-of-squares width
  localparam int RW   = (SW + 1) / 2;                        // root width
  localparam int AW   = 2*RW;                                // acc padded to whole bit pairs
  localparam int NB   = DATAWIDTH + FRAC_BITS;               // dividend / quotient bits
  localparam int QW   = 2*DATAWIDTH + 2;                     // output slot width
  localparam int KW   = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
  localparam int MAXC = (RW > NB) ? RW : NB;
  localparam int CW   = $clog2(MAXC + 1);

  // Elaboration-time parameter sanity.
  if (FRAC_BITS < 0 || FRAC_BITS > DATAWIDTH + 2) begin : g_bad_frac
    $error("vec_normalizer_seq: FRAC_BITS out of range");
  end
  if (NUM_CHANNELS < 1 || NUM_CHANNELS > 32) begin : g_bad_n
    $error("vec_normalizer_seq: NUM_CHANNELS out of range");
  end
  if (INSTANCE_ID < 0) begin : g_bad_id
    $error("vec_normalizer_seq: INSTANCE_ID must be non-negative");
  end

  typedef enum logic [2:0] {S_IDLE, S_ACC, S_SQRT, S_DIV, S_OUT} state_t;

  state_t state_q, state_d;

  logic [NUM_CHANNELS*DATAWIDTH-1:0]  x_q;
  logic [AW-1:0]                      acc_q;
  logic [RW-1:0]                      root_q;
  logic [RW:0]                        sq_rem_q;
  logic [RW-1:0]                      dr_q;
  logic [NB-1:0]                      dvd_q;
  logic [NB-1:0]                      quo_q;
  logic [KW-1:0]                      k_q;
  logic [CW-1:0]                      cnt_q;
  logic                               zero_q;
  logic [NUM_CHANNELS*QW-1:0]         o_data_q;

  logic k_last, acc_last, sqrt_last, bit_last;

  assign k_last    = (k_q == KW'(NUM_CHANNELS - 1));
  assign sqrt_last = (cnt_q == CW'(RW - 1));
  assign bit_last  = (cnt_q == CW'(NB - 1));
  assign acc_last  = k_last;

  // ---------------- next-state logic ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (i_valid)              state_d = S_ACC;
      S_ACC:  if (acc_last)             state_d = S_SQRT;
      S_SQRT: if (sqrt_last)            state_d = S_DIV;
      S_DIV:  if (bit_last && k_last)   state_d = S_OUT;
      S_OUT:  if (o_ready)              state_d = S_IDLE;
      default:                          state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // ---------------- datapath combinational ----------------
  logic [DATAWIDTH-1:0] x_k;
  logic [AW-1:0]        x_ext;
  logic [AW-1:0]        sq;
  logic [RW+2:0]        sr_next, sr_trial;
  logic                 sr_ge;
  logic [RW:0]          sq_rem_d;
  logic [RW-1:0]        root_d;
  logic [NB-1:0]        dvd_cur;
  logic [RW-1:0]        rem_cur;
  logic [NB-1:0]        quo_cur;
  logic [RW:0]          dr_try, root_ext;
  logic                 dr_ge;
  logic [RW-1:0]        dr_d;
  logic [NB-1:0]        quo_d;

  always_comb begin
    x_k   = x_q[int'(k_q)*DATAWIDTH +: DATAWIDTH];
    x_ext = AW'(x_k);
    sq    = x_ext * x_ext;

    // Digit-by-digit root: bring down the next bit pair of acc, try (4*root+1).
    sr_next  = {sq_rem_q, acc_q[AW-1 -: 2]};
    sr_trial = {1'b0, root_q, 2'b01};
    sr_ge    = (sr_next >= sr_trial);
    sq_rem_d = (RW+1)'(sr_ge ? sr_next - sr_trial : sr_next);
    root_d   = RW'({root_q, sr_ge});

    // First bit of each channel starts from a fresh dividend, zero remainder.
    dvd_cur  = (cnt_q == '0) ? (NB'(x_k) << FRAC_BITS) : dvd_q;
    rem_cur  = (cnt_q == '0) ? '0 : dr_q;
    quo_cur  = (cnt_q == '0) ? '0 : quo_q;
    dr_try   = {rem_cur, dvd_cur[NB-1]};
    root_ext = {1'b0, root_q};
    dr_ge    = (dr_try >= root_ext);
    // A zero root makes the remainder garbage, but the quotient is forced to 0 below.
    dr_d     = RW'(dr_ge ? dr_try - root_ext : dr_try);
    quo_d    = NB'({quo_cur, dr_ge});
  end

  // ---------------- datapath registers ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x_q      <= '0;
      acc_q    <= '0;
      root_q   <= '0;
      sq_rem_q <= '0;
      dr_q     <= '0;
      dvd_q    <= '0;
      quo_q    <= '0;
      k_q      <= '0;
      cnt_q    <= '0;
      zero_q   <= 1'b0;
      o_data_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (i_valid) begin
            x_q      <= i_data;
            acc_q    <= '0;
            root_q   <= '0;
            sq_rem_q <= '0;
            k_q      <= '0;
            cnt_q    <= '0;
            zero_q   <= 1'b0;
          end
        end
        S_ACC: begin
          acc_q <= acc_q + sq;
          k_q   <= acc_last ? '0 : k_q + KW'(1);
        end
        S_SQRT: begin
          acc_q    <= acc_q << 2;
          sq_rem_q <= sq_rem_d;
          root_q   <= root_d;
          if (sqrt_last) begin
            cnt_q  <= '0;
            zero_q <= (root_d == '0);
          end else begin
            cnt_q  <= cnt_q + CW'(1);
          end
        end
        S_DIV: begin
          dvd_q <= dvd_cur << 1;
          dr_q  <= dr_d;
          quo_q <= quo_d;
          if (bit_last) begin
            o_data_q[int'(k_q)*QW +: QW] <= zero_q ? '0 : QW'(quo_d);
            cnt_q <= '0;
            k_q   <= k_last ? '0 : k_q + KW'(1);
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        S_OUT: begin
          if (o_ready) zero_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign i_ready = (state_q == S_IDLE);
  assign o_valid = (state_q == S_OUT);
  assign o_data  = o_data_q;
  assign o_zero  = zero_q & o_valid;

endmodule

// File: tb/tb_vec_normalizer_seq.sv
// Directed bench for vec_normalizer_seq: default instance plus N=3/DW=8/FB=8 and N=1 instances.
// Latency checked per vector against N + RW + N*NB.
// Backpressure: holds o_ready low with input traffic, then checks release and reset abort.
module tb_vec_normalizer_seq;

  localparam int A_LAT = 4 + 5 + 32;   // N=4, RW=5, NB=8
  localparam int B_LAT = 3 + 9 + 48;   // N=3, RW=9, NB=16
  localparam int C_LAT = 1 + 4 + 8;    // N=1, RW=4, NB=8

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Default instance
  logic        a_valid = 1'b0, a_oready = 1'b0;
  logic        a_ready, a_ovalid, a_zero;
  logic [15:0] a_data = '0;
  logic [39:0] a_odata;

  // N=3, DATAWIDTH=8, FRAC_BITS=8
  logic        b_valid = 1'b0, b_oready = 1'b0;
  logic        b_ready, b_ovalid, b_zero;
  logic [23:0] b_data = '0;
  logic [53:0] b_odata;

  // N=1, defaults otherwise
  logic        c_valid = 1'b0, c_oready = 1'b0;
  logic        c_ready, c_ovalid, c_zero;
  logic [3:0]  c_data = '0;
  logic [9:0]  c_odata;

  vec_normalizer_seq u_a (
    .clk(clk), .rst(rst),
    .i_valid(a_valid), .i_ready(a_ready), .i_data(a_data),
    .o_valid(a_ovalid), .o_ready(a_oready), .o_data(a_odata), .o_zero(a_zero)
  );

  vec_normalizer_seq #(.DATAWIDTH(8), .FRAC_BITS(8), .NUM_CHANNELS(3), .INSTANCE_ID(1)) u_b (
    .clk(clk), .rst(rst),
    .i_valid(b_valid), .i_ready(b_ready), .i_data(b_data),
    .o_valid(b_ovalid), .o_ready(b_oready), .o_data(b_odata), .o_zero(b_zero)
  );

  vec_normalizer_seq #(.NUM_CHANNELS(1), .INSTANCE_ID(2)) u_c (
    .clk(clk), .rst(rst),
    .i_valid(c_valid), .i_ready(c_ready), .i_data(c_data),
    .o_valid(c_ovalid), .o_ready(c_oready), .o_data(c_odata), .o_zero(c_zero)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] a_in(input int x0, input int x1, input int x2, input int x3);
    return {4'(x3), 4'(x2), 4'(x1), 4'(x0)};
  endfunction

  function automatic logic [39:0] a_out(input int q0, input int q1, input int q2, input int q3);
    return {10'(q3), 10'(q2), 10'(q1), 10'(q0)};
  endfunction

  function automatic logic [23:0] b_in(input int x0, input int x1, input int x2);
    return {8'(x2), 8'(x1), 8'(x0)};
  endfunction

  function automatic logic [53:0] b_out(input int q0, input int q1, input int q2);
    return {18'(q2), 18'(q1), 18'(q0)};
  endfunction

  // ---------------- default instance helpers ----------------
  task automatic a_start(input logic [15:0] d);
    check("a_irdy_idle", 64'(a_ready), 64'd1);
    a_data  = d;
    a_valid = 1'b1;
    @(posedge clk); #1;
    a_valid = 1'b0;
    check("a_irdy_busy", 64'(a_ready), 64'd0);
  endtask

  task automatic a_wait(input string tag, input logic [39:0] exp, input logic exp_zero);
    int lat = 0;
    while (a_ovalid !== 1'b1 && lat < 400) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_lat"},  64'(lat),     64'(A_LAT));
    check({tag, "_data"}, 64'(a_odata), 64'(exp));
    check({tag, "_zero"}, 64'(a_zero),  64'(exp_zero));
  endtask

  task automatic a_finish(input string tag);
    a_oready = 1'b1;
    @(posedge clk); #1;
    a_oready = 1'b0;
    check({tag, "_done_vld"},  64'(a_ovalid), 64'd0);
    check({tag, "_done_irdy"}, 64'(a_ready),  64'd1);
    check({tag, "_done_zero"}, 64'(a_zero),   64'd0);
  endtask

  task automatic a_run(input string tag, input logic [15:0] d, input logic [39:0] exp,
                       input logic exp_zero);
    a_start(d);
    a_wait(tag, exp, exp_zero);
    a_finish(tag);
  endtask

  // ---------------- N=3 wide instance ----------------
  task automatic b_run(input string tag, input logic [23:0] d, input logic [53:0] exp,
                       input logic exp_zero);
    int lat = 0;
    b_data  = d;
    b_valid = 1'b1;
    @(posedge clk); #1;
    b_valid = 1'b0;
    while (b_ovalid !== 1'b1 && lat < 400) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_lat"},  64'(lat),     64'(B_LAT));
    check({tag, "_data"}, 64'(b_odata), 64'(exp));
    check({tag, "_zero"}, 64'(b_zero),  64'(exp_zero));
    b_oready = 1'b1;
    @(posedge clk); #1;
    b_oready = 1'b0;
    check({tag, "_done_vld"}, 64'(b_ovalid), 64'd0);
  endtask

  // ---------------- N=1 instance ----------------
  task automatic c_run(input string tag, input logic [3:0] d, input logic [9:0] exp,
                       input logic exp_zero);
    int lat = 0;
    c_data  = d;
    c_valid = 1'b1;
    @(posedge clk); #1;
    c_valid = 1'b0;
    while (c_ovalid !== 1'b1 && lat < 400) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_lat"},  64'(lat),     64'(C_LAT));
    check({tag, "_data"}, 64'(c_odata), 64'(exp));
    check({tag, "_zero"}, 64'(c_zero),  64'(exp_zero));
    c_oready = 1'b1;
    @(posedge clk); #1;
    c_oready = 1'b0;
    check({tag, "_done_vld"}, 64'(c_ovalid), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #2;
    check("rst_irdy",  64'(a_ready),  64'd1);
    check("rst_ovld",  64'(a_ovalid), 64'd0);
    check("rst_odata", 64'(a_odata),  64'd0);
    check("rst_ozero", 64'(a_zero),   64'd0);
    check("rst_b_irdy", 64'(b_ready), 64'd1);
    check("rst_c_ovld", 64'(c_ovalid), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Main function, default parameters
    a_run("v3400",  a_in(3, 4, 0, 0),     a_out(9, 12, 0, 0),   1'b0);
    a_run("v15x4",  a_in(15, 15, 15, 15), a_out(8, 8, 8, 8),    1'b0);
    a_run("v1110",  a_in(1, 1, 1, 0),     a_out(16, 16, 16, 0), 1'b0);
    a_run("vzero",  a_in(0, 0, 0, 0),     a_out(0, 0, 0, 0),    1'b1);
    a_run("v15000", a_in(15, 0, 0, 0),    a_out(16, 0, 0, 0),   1'b0);
    a_run("v1234",  a_in(1, 2, 3, 4),     a_out(3, 6, 9, 12),   1'b0);
    a_run("v7001",  a_in(7, 0, 0, 1),     a_out(16, 0, 0, 2),   1'b0);

    // Backpressure: output held, no capture while busy
    a_start(a_in(3, 4, 0, 0));
    a_wait("bp", a_out(9, 12, 0, 0), 1'b0);
    for (int i = 0; i < 10; i++) begin
      a_valid = i[0];
      a_data  = 16'($urandom);
      @(posedge clk); #1;
      check("bp_hold_data", 64'(a_odata),  64'(a_out(9, 12, 0, 0)));
      check("bp_hold_vld",  64'(a_ovalid), 64'd1);
      check("bp_irdy",      64'(a_ready),  64'd0);
    end
    a_valid = 1'b0;
    a_finish("bp");
    a_run("after_bp", a_in(1, 2, 3, 4), a_out(3, 6, 9, 12), 1'b0);

    // Reset in the middle of the divide phase
    a_start(a_in(15, 15, 15, 15));
    repeat (19) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("midrst_vld",   64'(a_ovalid), 64'd0);
    check("midrst_irdy",  64'(a_ready),  64'd1);
    check("midrst_odata", 64'(a_odata),  64'd0);
    check("midrst_zero",  64'(a_zero),   64'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    a_run("post_rst", a_in(1, 1, 1, 0), a_out(16, 16, 16, 0), 1'b0);

    // N=3, DATAWIDTH=8, FRAC_BITS=8
    b_run("b_full",  b_in(255, 255, 255), b_out(148, 148, 148), 1'b0);
    b_run("b_100",   b_in(100, 0, 1),     b_out(256, 0, 2),     1'b0);
    b_run("b_3412",  b_in(3, 4, 12),      b_out(59, 78, 236),   1'b0);
    b_run("b_zero",  b_in(0, 0, 0),       b_out(0, 0, 0),       1'b1);

    // N=1
    c_run("c_9",    4'd9, 10'd16, 1'b0);
    c_run("c_zero", 4'd0, 10'd0,  1'b1);
    c_run("c_1",    4'd1, 10'd16, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
